bm_memory_arbiter: RTL and testbench
====================================

# bm_memory_arbiter

Two-port round-robin arbiter wrapped around a small synchronous word memory, letting two independent requesters (A and B) share one single-ported array. After reset it runs a hardware clear sequence that zeroes every word, then serves at most one read or write per cycle. It sits between requester logic and the memory array in the syntax/benchmark suite and exercises FSMs, counters, memory inference and arbitration together.

## Interface
- `BITS`, 2, address width; memory depth DEPTH = 2^BITS words
- `WORD_SIZE`, 4, data word width
- `clock`  input  1  sole clock; all state updates on posedge
- `reset`  input  1  synchronous, active-high reset
- `req_a` / `req_b`  input  1  access request from A / B; held until granted
- `we_a` / `we_b`  input  1  1 = write, 0 = read; valid with req
- `addr_a` / `addr_b`  input  BITS  word address
- `wdata_a` / `wdata_b`  input  WORD_SIZE  write data
- `gnt_a` / `gnt_b`  output  1  combinational grant; access commits at the next posedge
- `rvalid_a` / `rvalid_b`  output  1  registered one-cycle pulse: read data ready
- `rdata_a` / `rdata_b`  output  WORD_SIZE  registered read data; holds last value
- `busy`  output  1  high while the clear sequence runs

## Operation
- FSM states: INIT (clear), RUN. Reset forces INIT.
- Reset values: state=INIT, clr_cnt=0, last_gnt=B (A wins the first tie), rvalid_a/b=0, rdata_a/b=0, busy=1, gnt_a/b=0.
- INIT: each cycle write 0 to mem[clr_cnt], clr_cnt += 1. The cycle that writes address DEPTH-1 transitions to RUN. gnt_a/b are forced 0 throughout; requests are not lost, only stalled. busy=1 in INIT, 0 in RUN.
- RUN arbitration, combinational:
  - only req_a → gnt_a
  - only req_b → gnt_b
  - both → the requester that is not last_gnt
  - none → no grant
- At most one grant per cycle; gnt_a and gnt_b are never both 1.
- last_gnt updates only on a cycle with a grant; idle cycles keep it.
- Granted write: mem[addr] ← wdata at the edge. No rvalid.
- Granted read: at the edge rdata_x ← mem[addr] and rvalid_x ← 1. The other port's rvalid ← 0.
- A cycle with no granted read drives both rvalid to 0. rdata is otherwise held.
- Memory contents persist across RUN cycles. Only reset (via INIT) clears them.

## Timing
- Clear sequence: busy high for exactly DEPTH cycles after reset deasserts. The first grant is possible in cycle DEPTH (0-indexed from the first non-reset edge).
- Read latency: 1 cycle from the granted edge to rvalid/rdata.
- Write-then-read, same address, consecutive grants: the read returns the new data.
- Sustained contention: grants alternate A, B, A, B …; each requester is served at least every second cycle.
- Reset asserted mid-RUN or mid-INIT: the next edge applies reset values and discards any in-flight rvalid. The clear restarts from address 0.
- Requester rule: keep req, we, addr and wdata stable until the grant is seen. Drop req in the cycle after the grant to avoid a second access.

## Test plan
- Reset, then idle: busy high for 4 cycles, then 0. Read A of addr 0–3 → rdata_a=0 for each, one cycle after each grant.
- After INIT, A writes 4'hA to addr 2. Next cycle A reads addr 2 → rvalid_a pulses 1 cycle later with rdata_a=4'hA; rvalid_b stays 0.
- First post-INIT cycle with req_a and req_b both held for 4 cycles → grants A, B, A, B. Then A only for 2 cycles → A, A.
- req_b asserted during INIT (cycle 1) → gnt_b=0 until busy falls, then gnt_b in the first RUN cycle.
- B writes 4'h5 to addr 3. Reset is pulsed 1 cycle, then INIT completes. A reads addr 3 → 0, and busy was high for 4 cycles after the pulse.
- Contention where A wins a read of addr 1 (4'h7) and B's write of 4'hC to addr 1 follows → rdata_a=4'h7. B's later read returns 4'hC.

Source files
------------

// File: rtl/bm_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bm_memory_arbiter
// Brief    : Two-port round-robin arbiter in front of a single-ported word
//            memory, with a post-reset hardware clear sequence.
// Revision : 1.0 - initial release
// ============================================================================
module bm_memory_arbiter #(
  parameter int BITS      = 2,
  parameter int WORD_SIZE = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_a,
  input  logic                 req_b,
  input  logic                 we_a,
  input  logic                 we_b,
  input  logic [BITS-1:0]      addr_a,
  input  logic [BITS-1:0]      addr_b,
  input  logic [WORD_SIZE-1:0] wdata_a,
  input  logic [WORD_SIZE-1:0] wdata_b,
  output logic                 gnt_a,
  output logic                 gnt_b,
  output logic                 rvalid_a,
  output logic                 rvalid_b,
  output logic [WORD_SIZE-1:0] rdata_a,
  output logic [WORD_SIZE-1:0] rdata_b,
  output logic                 busy
);

  localparam int DEPTH = 1 << BITS;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 r_state;
  logic [BITS-1:0]        r_clr_cnt;
  logic                   r_last_a;
  logic                   r_rvalid_a;
  logic                   r_rvalid_b;
  logic [WORD_SIZE-1:0]   r_rdata_a;
  logic [WORD_SIZE-1:0]   r_rdata_b;
  logic [WORD_SIZE-1:0]   r_mem [DEPTH];

  logic                   w_run;
  logic                   w_gnt_a;
  logic                   w_gnt_b;
  logic                   w_mem_we;
  logic [BITS-1:0]        w_mem_addr;
  logic [WORD_SIZE-1:0]   w_mem_wdata;

  // On a tie the requester that was not served last wins.
  assign w_run   = (r_state == RUN);
  assign w_gnt_a = w_run & req_a & (~req_b | ~r_last_a);
  assign w_gnt_b = w_run & req_b & (~req_a |  r_last_a);

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = r_clr_cnt;
    w_mem_wdata = '0;
    if (!w_run) begin
      w_mem_we = 1'b1;
    end else if (w_gnt_a) begin
      w_mem_we    = we_a;
      w_mem_addr  = addr_a;
      w_mem_wdata = wdata_a;
    end else if (w_gnt_b) begin
      w_mem_we    = we_b;
      w_mem_addr  = addr_b;
      w_mem_wdata = wdata_b;
    end
  end

  // Array has no reset; the INIT sequence is what clears it.
  always_ff @(posedge clock) begin
    if (!reset && w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= INIT;
      r_clr_cnt  <= '0;
      r_last_a   <= 1'b0;
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
      r_rdata_a  <= '0;
      r_rdata_b  <= '0;
    end else begin
      r_rvalid_a <= w_gnt_a & ~we_a;
      r_rvalid_b <= w_gnt_b & ~we_b;
      if (w_gnt_a && !we_a) begin
        r_rdata_a <= r_mem[addr_a];
      end
      if (w_gnt_b && !we_b) begin
        r_rdata_b <= r_mem[addr_b];
      end
      if (w_gnt_a || w_gnt_b) begin
        r_last_a <= w_gnt_a;
      end
      case (r_state)
        INIT: begin
          r_clr_cnt <= r_clr_cnt + BITS'(1);
          if (r_clr_cnt == BITS'(DEPTH - 1)) begin
            r_state <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign gnt_a    = w_gnt_a;
  assign gnt_b    = w_gnt_b;
  assign rvalid_a = r_rvalid_a;
  assign rvalid_b = r_rvalid_b;
  assign rdata_a  = r_rdata_a;
  assign rdata_b  = r_rdata_b;
  assign busy     = ~w_run;

endmodule
`default_nettype wire

// File: tb/tb_bm_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bm_memory_arbiter
// Brief    : Self-checking bench: directed scenarios plus randomized traffic
//            against a behavioural memory/arbitration model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bm_memory_arbiter;

  localparam int BITS      = 2;
  localparam int WORD_SIZE = 4;
  localparam int DEPTH     = 4;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic                 req_a = 1'b0, req_b = 1'b0;
  logic                 we_a = 1'b0, we_b = 1'b0;
  logic [BITS-1:0]      addr_a = '0, addr_b = '0;
  logic [WORD_SIZE-1:0] wdata_a = '0, wdata_b = '0;
  logic                 gnt_a, gnt_b, rvalid_a, rvalid_b, busy;
  logic [WORD_SIZE-1:0] rdata_a, rdata_b;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  bm_memory_arbiter #(.BITS(BITS), .WORD_SIZE(WORD_SIZE)) dut (
    .clock(clock), .reset(reset),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .busy(busy)
  );

  task automatic set_port(input bit b, input bit rq, input bit we,
                          input logic [BITS-1:0] ad, input logic [WORD_SIZE-1:0] wd);
    if (b) begin req_b = rq; we_b = we; addr_b = ad; wdata_b = wd; end
    else   begin req_a = rq; we_a = we; addr_a = ad; wdata_a = wd; end
  endtask

  // Leaves the bench at the negedge of cycle 0 (first cycle after reset).
  task automatic do_reset();
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic wait_run(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      @(negedge clock);
    end
  endtask

  // Hold a request until granted, then drop it; returns one cycle after the grant edge.
  task automatic access(input bit b, input bit we, input logic [BITS-1:0] ad,
                        input logic [WORD_SIZE-1:0] wd, output bit ok);
    set_port(b, 1'b1, we, ad, wd);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (b ? gnt_b : gnt_a) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    @(negedge clock);
    set_port(b, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    int n;
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b exp 1", busy); end
    checks++; if ({gnt_a, gnt_b, rvalid_a, rvalid_b} !== 4'b0000) begin errors++;
      $display("FAIL reset_flags got %b exp 0000", {gnt_a, gnt_b, rvalid_a, rvalid_b}); end
    checks++; if ({rdata_a, rdata_b} !== 8'h00) begin errors++;
      $display("FAIL reset_rdata got %h exp 00", {rdata_a, rdata_b}); end
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && busy === 1'b1; i++) begin n++; @(negedge clock); end
    checks++; if (n !== DEPTH) begin errors++; $display("FAIL reset_busy_len got %0d exp %0d", n, DEPTH); end
  endtask

  task automatic test_write_read();
    bit ok;
    access(1'b0, 1'b1, 2'd2, 4'hA, ok);
    checks++; if (!ok || rvalid_a !== 1'b0) begin errors++;
      $display("FAIL wr_grant ok %b rvalid_a %b exp ok 1 rvalid 0", ok, rvalid_a); end
    access(1'b0, 1'b0, 2'd2, 4'h0, ok);
    checks++; if (!ok || rvalid_a !== 1'b1 || rdata_a !== 4'hA) begin errors++;
      $display("FAIL rd_after_wr ok %b rvalid %b rdata %h exp 1 1 a", ok, rvalid_a, rdata_a); end
    checks++; if (rvalid_b !== 1'b0) begin errors++; $display("FAIL rd_other_rvalid got %b exp 0", rvalid_b); end
    @(negedge clock);
    checks++; if (rvalid_a !== 1'b0 || rdata_a !== 4'hA) begin errors++;
      $display("FAIL rd_hold rvalid %b rdata %h exp 0 a", rvalid_a, rdata_a); end
  endtask

  task automatic test_reset_clears();
    bit ok;
    int n;
    access(1'b1, 1'b1, 2'd3, 4'h5, ok);
    access(1'b0, 1'b0, 2'd2, 4'h0, ok);
    checks++; if (!ok || rvalid_a !== 1'b1 || rdata_a !== 4'hA) begin errors++;
      $display("FAIL pre_reset_rd rvalid %b rdata %h exp 1 a", rvalid_a, rdata_a); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (rvalid_a !== 1'b0 || rdata_a !== 4'h0 || busy !== 1'b1) begin errors++;
      $display("FAIL midrun_reset rvalid %b rdata %h busy %b exp 0 0 1", rvalid_a, rdata_a, busy); end
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && busy === 1'b1; i++) begin n++; @(negedge clock); end
    checks++; if (n !== DEPTH) begin errors++; $display("FAIL pulse_busy_len got %0d exp %0d", n, DEPTH); end
    for (int a = 0; a < DEPTH; a++) begin
      access(1'b0, 1'b0, BITS'(a), 4'h0, ok);
      checks++; if (!ok || rvalid_a !== 1'b1 || rdata_a !== 4'h0) begin errors++;
        $display("FAIL clear_rd addr %0d rvalid %b rdata %h exp 1 0", a, rvalid_a, rdata_a); end
    end
  endtask

  task automatic test_contention();
    bit ok;
    do_reset();
    wait_run(ok);
    checks++; if (!ok) begin errors++; $display("FAIL cont_wait_run busy %b exp 0", busy); end
    set_port(1'b0, 1'b1, 1'b0, 2'd0, 4'h0);
    set_port(1'b1, 1'b1, 1'b0, 2'd1, 4'h0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        checks++; if (rvalid_a !== (k % 2 == 1) || rvalid_b !== (k % 2 == 0)) begin errors++;
          $display("FAIL cont_rvalid k %0d got %b%b", k, rvalid_a, rvalid_b); end
      end
      #1;
      checks++; if (gnt_a !== (k % 2 == 0) || gnt_b !== (k % 2 == 1)) begin errors++;
        $display("FAIL cont_gnt k %0d got %b%b exp %b%b", k, gnt_a, gnt_b, k % 2 == 0, k % 2 == 1); end
      @(negedge clock);
    end
    req_b = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin errors++;
        $display("FAIL solo_gnt k %0d got %b%b exp 10", k, gnt_a, gnt_b); end
      @(negedge clock);
    end
    req_a = 1'b0;
  endtask

  task automatic test_req_during_init();
    int n;
    do_reset();
    @(negedge clock);
    set_port(1'b1, 1'b1, 1'b0, 2'd0, 4'h0);
    n = 0;
    for (int i = 0; i < 20 && busy === 1'b1; i++) begin
      #1;
      checks++; if (gnt_b !== 1'b0 || gnt_a !== 1'b0) begin errors++;
        $display("FAIL init_gnt cyc %0d got %b%b exp 00", i, gnt_a, gnt_b); end
      n++;
      @(negedge clock);
    end
    checks++; if (n !== DEPTH - 1) begin errors++; $display("FAIL init_stall got %0d exp %0d", n, DEPTH - 1); end
    #1;
    checks++; if (gnt_b !== 1'b1) begin errors++; $display("FAIL init_first_gnt got %b exp 1", gnt_b); end
    @(negedge clock);
    req_b = 1'b0;
    checks++; if (rvalid_b !== 1'b1 || rdata_b !== 4'h0) begin errors++;
      $display("FAIL init_rd rvalid %b rdata %h exp 1 0", rvalid_b, rdata_b); end
  endtask

  task automatic test_read_before_write();
    bit ok;
    access(1'b0, 1'b1, 2'd1, 4'h7, ok);
    access(1'b1, 1'b0, 2'd0, 4'h0, ok);
    set_port(1'b0, 1'b1, 1'b0, 2'd1, 4'h0);
    set_port(1'b1, 1'b1, 1'b1, 2'd1, 4'hC);
    #1;
    checks++; if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin errors++;
      $display("FAIL rbw_first got %b%b exp 10", gnt_a, gnt_b); end
    @(negedge clock);
    req_a = 1'b0;
    checks++; if (rvalid_a !== 1'b1 || rdata_a !== 4'h7) begin errors++;
      $display("FAIL rbw_old_data rvalid %b rdata %h exp 1 7", rvalid_a, rdata_a); end
    #1;
    checks++; if (gnt_b !== 1'b1) begin errors++; $display("FAIL rbw_second got %b exp 1", gnt_b); end
    @(negedge clock);
    req_b = 1'b0;
    access(1'b1, 1'b0, 2'd1, 4'h0, ok);
    checks++; if (!ok || rvalid_b !== 1'b1 || rdata_b !== 4'hC) begin errors++;
      $display("FAIL rbw_new_data rvalid %b rdata %h exp 1 c", rvalid_b, rdata_b); end
  endtask

  task automatic test_random();
    bit ok;
    logic [WORD_SIZE-1:0] mem [DEPTH];
    bit last_b, pa, pb, wa, wb, cool_a, cool_b, exp_ga, exp_gb, exp_rv_a, exp_rv_b;
    logic [BITS-1:0] aa, ab;
    logic [WORD_SIZE-1:0] da, db, exp_rd_a, exp_rd_b;
    do_reset();
    wait_run(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rand_wait_run busy %b exp 0", busy); end
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    last_b = 1'b1; pa = 1'b0; pb = 1'b0; cool_a = 1'b0; cool_b = 1'b0;
    wa = 1'b0; wb = 1'b0; aa = '0; ab = '0; da = '0; db = '0;
    exp_rv_a = 1'b0; exp_rv_b = 1'b0; exp_rd_a = '0; exp_rd_b = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      checks++; if (rvalid_a !== exp_rv_a || rdata_a !== exp_rd_a) begin errors++;
        $display("FAIL rand_a cyc %0d rvalid %b rdata %h exp %b %h", cyc, rvalid_a, rdata_a, exp_rv_a, exp_rd_a); end
      checks++; if (rvalid_b !== exp_rv_b || rdata_b !== exp_rd_b) begin errors++;
        $display("FAIL rand_b cyc %0d rvalid %b rdata %h exp %b %h", cyc, rvalid_b, rdata_b, exp_rv_b, exp_rd_b); end
      if (!pa && !cool_a && $urandom_range(0, 2) != 0) begin
        pa = 1'b1; wa = 1'($urandom_range(0, 1));
        aa = BITS'($urandom_range(0, DEPTH - 1)); da = WORD_SIZE'($urandom_range(0, 15));
      end
      if (!pb && !cool_b && $urandom_range(0, 2) != 0) begin
        pb = 1'b1; wb = 1'($urandom_range(0, 1));
        ab = BITS'($urandom_range(0, DEPTH - 1)); db = WORD_SIZE'($urandom_range(0, 15));
      end
      cool_a = 1'b0; cool_b = 1'b0;
      set_port(1'b0, pa, wa, aa, da);
      set_port(1'b1, pb, wb, ab, db);
      #1;
      exp_ga = pa && (!pb || last_b);
      exp_gb = pb && !exp_ga;
      checks++; if (gnt_a !== exp_ga || gnt_b !== exp_gb) begin errors++;
        $display("FAIL rand_gnt cyc %0d got %b%b exp %b%b", cyc, gnt_a, gnt_b, exp_ga, exp_gb); end
      exp_rv_a = 1'b0; exp_rv_b = 1'b0;
      if (exp_ga) begin
        if (wa) mem[aa] = da; else begin exp_rv_a = 1'b1; exp_rd_a = mem[aa]; end
        last_b = 1'b0; pa = 1'b0; cool_a = 1'b1;
      end else if (exp_gb) begin
        if (wb) mem[ab] = db; else begin exp_rv_b = 1'b1; exp_rd_b = mem[ab]; end
        last_b = 1'b1; pb = 1'b0; cool_b = 1'b1;
      end
      @(negedge clock);
    end
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_reset_clears();
    test_contention();
    test_req_during_init();
    test_read_before_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
